// File: rtl/serial_addsub_ctrl_pkg.sv
// rtl/serial_addsub_ctrl_pkg.sv - shared types and constants for the bit-serial add/subtract sequencer
package serial_addsub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int   DEFAULT_WIDTH = 8;
    localparam logic MODE_ADD      = 1'b1;
    localparam logic MODE_SUB      = 1'b0;
endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// rtl/serial_addsub_ctrl_if.sv - request/response handshake bundle for serial_addsub_ctrl
// ovf is carried only when SERIAL_ADDSUB_OVF_EN is defined.
interface serial_addsub_ctrl_if #(parameter int WIDTH = serial_addsub_pkg::DEFAULT_WIDTH);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_a_ns;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf;

    modport master (output in_valid, op_a, op_b, op_a_ns, out_ready,
                    input  in_ready, out_valid, result, carry_out, ovf);
    modport slave  (input  in_valid, op_a, op_b, op_a_ns, out_ready,
                    output in_ready, out_valid, result, carry_out, ovf);
`else
    modport master (output in_valid, op_a, op_b, op_a_ns, out_ready,
                    input  in_ready, out_valid, result, carry_out);
    modport slave  (input  in_valid, op_a, op_b, op_a_ns, out_ready,
                    output in_ready, out_valid, result, carry_out);
`endif
endinterface

// File: rtl/serial_addsub_ctrl_shreg.sv
// rtl/serial_addsub_ctrl_shreg.sv - parallel-load right-shift register, serial-in at MSB
// Priority: clear, then load, then shift.
module serial_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_shift,
    input  logic             i_sin,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_data;
        end else if (i_shift) begin
            r_q <= {i_sin, r_q[WIDTH-1:1]};
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - sequences an external fas cell over WIDTH bits, LSB first
// Optional signed-overflow output enabled by SERIAL_ADDSUB_OVF_EN.
module serial_addsub_ctrl import serial_addsub_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_addsub_ctrl_if.slave  bus,
    output logic                 busy,
    output logic                 fa_a,
    output logic                 fa_b,
    output logic                 fa_cin,
    output logic                 fa_a_ns,
    input  logic                 fa_s,
    input  logic                 fa_cout
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_mode;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_carry_out;
    logic [WIDTH-1:0] w_a_q;
    logic [WIDTH-1:0] w_b_q;
    logic [WIDTH-1:0] w_res_q;
    logic             w_accept;
    logic             w_last;
    logic             w_unused_bits;

    assign w_accept = r_in_ready && bus.in_valid;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADDSUB_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;
    logic w_ovf_next;

    // fa_s on the last RUN cycle is the result MSB
    assign w_ovf_next = (r_mode == MODE_ADD)
                      ? ((r_a_msb == r_b_msb) && (fa_s != r_a_msb))
                      : ((r_a_msb != r_b_msb) && (fa_s != r_a_msb));
    assign bus.ovf = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= bus.op_a[WIDTH-1];
            r_b_msb <= bus.op_b[WIDTH-1];
        end else if (r_state == RUN && w_last) begin
            r_ovf <= w_ovf_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_mode      <= MODE_ADD;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_carry_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_state    <= RUN;
                        r_cnt      <= '0;
                        r_carry    <= 1'b0;
                        r_mode     <= bus.op_a_ns;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    r_carry <= fa_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_carry_out <= fa_cout;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    serial_shreg #(.WIDTH(WIDTH)) u_a_sr (
        .clk(clk), .i_clr(rst), .i_load(w_accept), .i_load_data(bus.op_a),
        .i_shift(r_busy), .i_sin(1'b0), .o_q(w_a_q)
    );

    serial_shreg #(.WIDTH(WIDTH)) u_b_sr (
        .clk(clk), .i_clr(rst), .i_load(w_accept), .i_load_data(bus.op_b),
        .i_shift(r_busy), .i_sin(1'b0), .o_q(w_b_q)
    );

    serial_shreg #(.WIDTH(WIDTH)) u_res_sr (
        .clk(clk), .i_clr(rst || w_accept), .i_load(1'b0), .i_load_data('0),
        .i_shift(r_busy), .i_sin(fa_s), .o_q(w_res_q)
    );

    // only the LSBs of the operand registers feed the cell
    assign w_unused_bits = &{1'b0, w_a_q[WIDTH-1:1], w_b_q[WIDTH-1:1]};

    assign fa_a    = r_busy && w_a_q[0];
    assign fa_b    = r_busy && w_b_q[0];
    assign fa_cin  = r_busy && r_carry;
    assign fa_a_ns = r_busy ? r_mode : MODE_ADD;

    assign busy          = r_busy;
    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = w_res_q;
    assign bus.carry_out = r_carry_out;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - scoreboard bench for serial_addsub_ctrl with a behavioural fas cell
module tb_serial_addsub_ctrl;
    import serial_addsub_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         o;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, fa_a, fa_b, fa_cin, fa_a_ns, fa_s, fa_cout;

    serial_addsub_ctrl_if #(.WIDTH(W)) bus ();

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_a_ns(fa_a_ns),
        .fa_s(fa_s), .fa_cout(fa_cout)
    );

    assign fa_s    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = fa_a_ns ? ((fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b)))
                             : ((~fa_a & fa_b) | (~(fa_a ^ fa_b) & fa_cin));

    always #50 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (bus.out_valid) begin
            chk("valid_ready_exclusive", {31'd0, bus.in_ready}, 32'd0);
            if (bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result", {24'd0, bus.result}, {24'd0, e.r});
                    chk("carry_out", {31'd0, bus.carry_out}, {31'd0, e.c});
`ifdef SERIAL_ADDSUB_OVF_EN
                    chk("ovf", {31'd0, bus.ovf}, {31'd0, e.o});
`endif
                end
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        while (!bus.in_ready && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_out_valid();
        int k;
        k = 0;
        while (!bus.out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (!bus.out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         input logic [W-1:0] er, input logic ec, input logic eo);
        exp_t e;
        logic early;
        wait_ready();
        bus.op_a = a; bus.op_b = b; bus.op_a_ns = m; bus.in_valid = 1'b1;
        e.r = er; e.c = ec; e.o = eo;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        early = 1'b0;
        for (int k = 1; k <= W; k++) begin
            @(posedge clk); #1;
            if (k < W && bus.out_valid) early = 1'b1;
        end
        chk("latency_early", {31'd0, early}, 32'd0);
        chk("latency_valid", {31'd0, bus.out_valid}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        logic stable;
        bus.in_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
        bus.op_a_ns = MODE_ADD; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", {24'd0, bus.result}, 32'd0);
        chk("rst_carry_out", {31'd0, bus.carry_out}, 32'd0);
        chk("rst_fa_inputs", {28'd0, fa_a, fa_b, fa_cin, fa_a_ns}, 32'd1);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif

        do_op(8'h35, 8'h4A, MODE_ADD, 8'h7F, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, MODE_ADD, 8'h00, 1'b1, 1'b0);
        do_op(8'h50, 8'h20, MODE_SUB, 8'h30, 1'b0, 1'b0);
        do_op(8'h10, 8'h20, MODE_SUB, 8'hF0, 1'b1, 1'b0);
        do_op(8'h7F, 8'h01, MODE_ADD, 8'h80, 1'b0, 1'b1);
        do_op(8'h80, 8'h01, MODE_SUB, 8'h7F, 1'b0, 1'b1);
        do_op(8'h00, 8'h01, MODE_SUB, 8'hFF, 1'b1, 1'b0);

        // backpressure: out_ready low, in_valid held high throughout
        wait_ready();
        bus.out_ready = 1'b0;
        bus.op_a = 8'h12; bus.op_b = 8'h34; bus.op_a_ns = MODE_ADD; bus.in_valid = 1'b1;
        e.r = 8'h46; e.c = 1'b0; e.o = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        wait_out_valid();
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (!bus.out_valid || bus.in_ready || bus.result !== 8'h46) stable = 1'b0;
        end
        chk("backpressure_stable", {31'd0, stable}, 32'd1);
        bus.op_a = 8'hAA; bus.op_b = 8'h55;
        e.r = 8'hFF; e.c = 1'b0; e.o = 1'b0;
        exp_q.push_back(e);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("bp_next_accept", {31'd0, busy}, 32'd1);
        bus.in_valid = 1'b0;
        wait_out_valid();
        @(posedge clk); #1;

        // reset asserted during the 3rd RUN cycle aborts the operation
        wait_ready();
        bus.op_a = 8'h35; bus.op_b = 8'h4A; bus.op_a_ns = MODE_ADD; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("abort_fa_cin", {31'd0, fa_cin}, 32'd0);
        chk("abort_result", {24'd0, bus.result}, 32'd0);
        stable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (bus.out_valid) stable = 1'b0;
            @(posedge clk); #1;
        end
        chk("abort_no_out_valid", {31'd0, stable}, 32'd1);
        do_op(8'h01, 8'h01, MODE_ADD, 8'h02, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #(100 * 5000);
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/serial_addsub_ctrl.md
# serial_addsub_ctrl

Bit-serial add/subtract sequencer that time-shares a single external `fas` full adder/subtractor cell across a WIDTH-bit operation. It accepts two operands and a mode over a valid/ready handshake and presents one bit pair per clock to the `fas` cell, LSB first. It registers the cell's carry/borrow between cycles, assembles the result, and returns it with the final carry/borrow over a second valid/ready handshake. It sits between a requester and one gate-level `fas` instance wired at the same hierarchy level.

## Interface
Parameters:
- `WIDTH`, default 8, operand/result width in bits; must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand request valid.
- `in_ready`  out  1  block can accept a request.
- `op_a`  in  WIDTH  operand A.
- `op_b`  in  WIDTH  operand B.
- `op_a_ns`  in  1  mode: 1 = A+B, 0 = A−B.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  WIDTH  sum or difference, modulo 2^WIDTH.
- `carry_out`  out  1  final carry (add) or final borrow (subtract).
- `ovf`  out  1  signed overflow; present only with `SERIAL_ADDSUB_OVF_EN`.
- `busy`  out  1  state is RUN.
- `fa_a`, `fa_b`, `fa_cin`, `fa_a_ns`  out  1 each  drive the `fas` inputs `a`, `b`, `cin`, `a_ns`.
- `fa_s`, `fa_cout`  in  1 each  driven by the `fas` outputs `s`, `cout`.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: capture `op_a` and `op_b` into shift registers, latch the mode, set `carry_q`=0 and `cnt`=0, then go to RUN.
- **RUN**
  - `fa_a`=a_sr[0], `fa_b`=b_sr[0], `fa_cin`=carry_q, `fa_a_ns`=mode_q.
  - Each edge:
    - `carry_q`←`fa_cout`.
    - Result register shifts right with `fa_s` entering at the MSB.
    - a_sr and b_sr shift right.
    - `cnt`++.
  - When `cnt`==WIDTH−1: go to DONE, and `carry_out`←`fa_cout`.
- **DONE**
  - `out_valid`=1; `result`, `carry_out` and `ovf` are held stable.
  - On `out_ready`: go to IDLE.
- Cell arithmetic:
  - Add mode: s = a^b^cin, cout = carry.
  - Subtract mode: s = a^b^bin, cout = borrow = (~a&b)|(~(a^b)&bin).
  - The initial cin/borrow is always 0.
- Outside RUN: `fa_a`=`fa_b`=`fa_cin`=0 and `fa_a_ns`=1.
- `in_ready` is asserted only in IDLE, so a new request is never accepted while RUN or DONE is pending; `in_valid` in those states is ignored, not queued.
- `cnt` width is $clog2(WIDTH), and it is never compared beyond WIDTH−1.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready`=1, `out_valid`=0, `busy`=0.
  - `result`=0, `carry_out`=0, `ovf`=0.
  - `fa_*` at their idle values.
- Latency: if a request is accepted on edge E0, `out_valid` is high after edge E0+WIDTH.
- Throughput: minimum WIDTH+2 cycles per operation (WIDTH in RUN, ≥1 in DONE, 1 in IDLE).
- `fa_s`/`fa_cout` are sampled one full clock after `fa_*` change, so the clock period must exceed the worst-case `fas` propagation delay. The bench uses a period of 100 time units.
- Backpressure: `out_valid` stays high and outputs stay unchanged until `out_ready`; there is no timeout.
- Reset mid-operation (RUN or DONE): the next state is IDLE, the partial result is discarded, and `out_valid` is never asserted for the aborted operation.
- `out_valid` and `in_ready` are never high together.

## Configuration
- `SERIAL_ADDSUB_OVF_EN` defined:
  - `ovf` port present, registered on the RUN→DONE transition.
  - Add: `ovf` = (a_msb==b_msb)&&(r_msb!=a_msb).
  - Subtract: `ovf` = (a_msb!=b_msb)&&(r_msb!=a_msb).
  - The MSBs of the original operands are latched at capture.
- Not defined: no `ovf` port and no MSB latches; all other behaviour is identical.

## Structure
- Package `serial_addsub_pkg` holds:
  - the `state_t` enum (IDLE, RUN, DONE);
  - `DEFAULT_WIDTH`=8;
  - mode constants `MODE_ADD`=1'b1, `MODE_SUB`=1'b0.
- Sub-module `serial_shreg` (WIDTH-bit parallel-load, right-shift register with serial-in, enable and synchronous clear) is instantiated three times: A, B and result.
- The `fas` cell is not instantiated inside this block; the bench or parent connects it.

## Test plan
All scenarios use WIDTH=8 with a `fas` instance attached.
- **Add:** 0x35+0x4A → `result`=0x7F, `carry_out`=0; `out_valid` 8 edges after accept.
- **Add with carry:** 0xFF+0x01 → `result`=0x00, `carry_out`=1, `ovf`=0.
- **Subtract:** 0x50−0x20 → 0x30 with borrow 0; 0x10−0x20 → 0xF0 with borrow 1.
- **Overflow (`SERIAL_ADDSUB_OVF_EN`):** 0x7F+0x01 → 0x80 with `ovf`=1; 0x80−0x01 → 0x7F with `ovf`=1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles with `in_valid`=1 throughout → `result`/`out_valid` stable and `in_ready`=0; after `out_ready`, the next request is accepted 1 cycle later.
- **Reset mid-operation:** `rst` on the 3rd RUN cycle → IDLE next cycle, `out_valid` stays 0, `fa_cin`=0; a following 0x01+0x01 → 0x02.
